// File: rtl/retire_trace_monitor.sv
// Retire trace monitor: captures write-back retirements into a small FIFO drained
// over valid/ready, and sequences run/flush/done with saturating run counters.
module retire_trace_monitor #(
  parameter int XLEN         = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CYCLES = 5,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             end_program,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic [XLEN-1:0]  wb_data,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [XLEN-1:0]  trace_pc,
  output logic [4:0]       trace_rd,
  output logic [XLEN-1:0]  trace_data,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start; capture off, counters held
  // RUN   | program running; capture on, cycles counted
  // FLUSH | end_program seen; flush delay then wait for FIFO to drain
  // DONE  | finished; counters frozen until reset, draining still allowed
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [FW-1:0]   flush_cnt;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            empty;
  logic            full;
  logic            capture;
  logic            pop;
  logic            push;
  logic            drop;

  logic [XLEN-1:0] mem_pc   [FIFO_DEPTH];
  logic [XLEN-1:0] mem_data [FIFO_DEPTH];
  logic [4:0]      mem_rd   [FIFO_DEPTH];
  logic            mem_rw   [FIFO_DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign capture = (state == S_RUN) || (state == S_FLUSH);
  assign pop     = !empty && trace_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign push    = capture && wb_valid && (!full || pop);
  assign drop    = capture && wb_valid && full && !pop;

  assign busy        = capture;
  assign done        = (state == S_DONE);
  assign trace_valid = !empty;
  assign trace_pc    = empty ? '0 : mem_pc[rd_idx];
  assign trace_rd    = (!empty && mem_rw[rd_idx]) ? mem_rd[rd_idx] : '0;
  assign trace_data  = (!empty && mem_rw[rd_idx]) ? mem_data[rd_idx] : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (end_program) state_nxt = S_FLUSH;
      S_FLUSH: if ((flush_cnt == '0) && empty) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_RUN) && end_program)
        flush_cnt <= FLUSH_LOAD;
      else if ((state == S_FLUSH) && (flush_cnt != '0))
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage is not reset; the head outputs are gated by empty instead
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_idx]   <= wb_pc;
      mem_rd[wr_idx]   <= wb_rd;
      mem_rw[wr_idx]   <= wb_reg_write;
      mem_data[wr_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
      drop_count    <= '0;
    end else begin
      if (capture)             cycle_count   <= sat_inc(cycle_count);
      if (capture && wb_valid) instret_count <= sat_inc(instret_count);
      if (drop)                drop_count    <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Bench for retire_trace_monitor: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_retire_trace_monitor;
  localparam int XLEN  = 64;
  localparam int DEPTH = 8;
  localparam int FLUSH = 5;
  localparam int CNT_W = 32;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             end_program = 1'b0;
  logic             wb_valid = 1'b0;
  logic [XLEN-1:0]  wb_pc = '0;
  logic [4:0]       wb_rd = '0;
  logic             wb_reg_write = 1'b0;
  logic [XLEN-1:0]  wb_data = '0;
  logic             trace_ready = 1'b0;
  logic             trace_valid;
  logic [XLEN-1:0]  trace_pc;
  logic [4:0]       trace_rd;
  logic [XLEN-1:0]  trace_data;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;
  logic [CNT_W-1:0] drop_count;
  logic             busy;
  logic             done;

  retire_trace_monitor #(
    .XLEN(XLEN), .FIFO_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .end_program(end_program),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_rd(trace_rd), .trace_data(trace_data),
    .cycle_count(cycle_count), .instret_count(instret_count), .drop_count(drop_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    bit          rw;
    logic [63:0] data;
  } rec_t;

  typedef struct {
    bit start; bit endp; bit wbv; logic [63:0] pc; logic [4:0] rd; bit rw;
    logic [63:0] data; bit rdy;
    bit e_tv; logic [63:0] e_pc; logic [4:0] e_rd; logic [63:0] e_data;
    int e_cyc; int e_inst; int e_drop; bit e_busy; bit e_done;
  } vec_t;

  // reference model: phase 0 idle, 1 run, 2 flush, 3 done
  rec_t   q[$];
  int     m_state = 0;
  int     m_flush = 0;
  longint m_cyc = 0;
  longint m_inst = 0;
  longint m_drop = 0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    return (v >= CNT_MAX) ? v : v + 1;
  endfunction

  task automatic model_step();
    bit was_empty;
    rec_t r;
    was_empty = (q.size() == 0);
    if (!was_empty && trace_ready) void'(q.pop_front());
    if ((m_state == 1 || m_state == 2) && wb_valid) begin
      m_inst = sat(m_inst);
      if (q.size() < DEPTH) begin
        r.pc = wb_pc; r.rd = wb_rd; r.rw = wb_reg_write; r.data = wb_data;
        q.push_back(r);
      end else begin
        m_drop = sat(m_drop);
      end
    end
    case (m_state)
      0: if (start) m_state = 1;
      1: begin
        m_cyc = sat(m_cyc);
        if (end_program) begin m_state = 2; m_flush = FLUSH; end
      end
      2: begin
        m_cyc = sat(m_cyc);
        if (m_flush == 0 && was_empty) m_state = 3;
        else if (m_flush > 0) m_flush--;
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    logic [63:0] e_pc, e_rd, e_data;
    bit tv;
    tv = (q.size() > 0);
    e_pc = '0; e_rd = '0; e_data = '0;
    if (tv) begin
      e_pc = q[0].pc;
      if (q[0].rw) begin e_rd = 64'(q[0].rd); e_data = q[0].data; end
    end
    chk("m_valid", 64'(trace_valid), 64'(tv));
    chk("m_pc", trace_pc, e_pc);
    chk("m_rd", 64'(trace_rd), e_rd);
    chk("m_data", trace_data, e_data);
    chk("m_cycle", 64'(cycle_count), 64'(m_cyc));
    chk("m_instret", 64'(instret_count), 64'(m_inst));
    chk("m_drop", 64'(drop_count), 64'(m_drop));
    chk("m_busy", 64'(busy), 64'(m_state == 1 || m_state == 2));
    chk("m_done", 64'(done), 64'(m_state == 3));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    start = 1'b0; end_program = 1'b0; wb_valid = 1'b0; trace_ready = 1'b0;
    wb_reg_write = 1'b0; wb_pc = '0; wb_rd = '0; wb_data = '0;
    reset = 1'b0;
    #2;
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_pc", trace_pc, 64'd0);
    chk("rst_cycle", 64'(cycle_count), 64'd0);
    chk("rst_instret", 64'(instret_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    q.delete(); m_state = 0; m_flush = 0; m_cyc = 0; m_inst = 0; m_drop = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic retire(input logic [63:0] pc, input logic [4:0] rd, input bit rw,
                        input logic [63:0] data);
    wb_valid = 1'b1; wb_pc = pc; wb_rd = rd; wb_reg_write = rw; wb_data = data;
  endtask

  vec_t vec[13];

  initial begin
    int pops;
    logic [63:0] exp_pc;

    // basic run: 3 retirements, immediate drain, 5 flush cycles
    vec[0]  = '{1'b1,1'b0,1'b0,64'h0,5'd0,1'b0,64'h0,1'b1, 1'b0,64'h0,5'd0,64'h0, 0,0,0,1'b1,1'b0};
    vec[1]  = '{1'b0,1'b0,1'b1,64'h0,5'd5,1'b1,64'h4,1'b1, 1'b1,64'h0,5'd5,64'h4, 1,1,0,1'b1,1'b0};
    vec[2]  = '{1'b0,1'b0,1'b1,64'h4,5'd6,1'b1,64'h4,1'b1, 1'b1,64'h4,5'd6,64'h4, 2,2,0,1'b1,1'b0};
    vec[3]  = '{1'b0,1'b0,1'b1,64'h8,5'd7,1'b1,64'h4,1'b1, 1'b1,64'h8,5'd7,64'h4, 3,3,0,1'b1,1'b0};
    vec[4]  = '{1'b0,1'b0,1'b0,64'h0,5'd0,1'b0,64'h0,1'b1, 1'b0,64'h0,5'd0,64'h0, 4,3,0,1'b1,1'b0};
    vec[5]  = '{1'b0,1'b1,1'b0,64'h0,5'd0,1'b0,64'h0,1'b1, 1'b0,64'h0,5'd0,64'h0, 5,3,0,1'b1,1'b0};
    for (int i = 6; i <= 10; i++)
      vec[i] = '{1'b0,1'b1,1'b0,64'h0,5'd0,1'b0,64'h0,1'b1, 1'b0,64'h0,5'd0,64'h0, i,3,0,1'b1,1'b0};
    vec[11] = '{1'b0,1'b1,1'b0,64'h0,5'd0,1'b0,64'h0,1'b1, 1'b0,64'h0,5'd0,64'h0, 11,3,0,1'b0,1'b1};
    vec[12] = '{1'b1,1'b1,1'b1,64'h40,5'd9,1'b1,64'h1,1'b1, 1'b0,64'h0,5'd0,64'h0, 11,3,0,1'b0,1'b1};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      start = vec[i].start; end_program = vec[i].endp; wb_valid = vec[i].wbv;
      wb_pc = vec[i].pc; wb_rd = vec[i].rd; wb_reg_write = vec[i].rw;
      wb_data = vec[i].data; trace_ready = vec[i].rdy;
      cycle();
      chk($sformatf("v%0d_valid", i), 64'(trace_valid), 64'(vec[i].e_tv));
      chk($sformatf("v%0d_pc", i), trace_pc, vec[i].e_pc);
      chk($sformatf("v%0d_rd", i), 64'(trace_rd), 64'(vec[i].e_rd));
      chk($sformatf("v%0d_data", i), trace_data, vec[i].e_data);
      chk($sformatf("v%0d_cycle", i), 64'(cycle_count), 64'(vec[i].e_cyc));
      chk($sformatf("v%0d_instret", i), 64'(instret_count), 64'(vec[i].e_inst));
      chk($sformatf("v%0d_drop", i), 64'(drop_count), 64'(vec[i].e_drop));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vec[i].e_busy));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(vec[i].e_done));
    end

    // overflow: 10 retirements into 8 slots with the consumer stalled
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      retire(64'(i * 4), 5'(i + 1), 1'b1, 64'(i + 100));
      cycle();
    end
    wb_valid = 1'b0;
    chk("ovf_drop", 64'(drop_count), 64'd2);
    chk("ovf_instret", 64'(instret_count), 64'd10);
    chk("ovf_valid", 64'(trace_valid), 64'd1);
    trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_pc", k), trace_pc, 64'(k * 4));
      chk($sformatf("drain%0d_rd", k), 64'(trace_rd), 64'(k + 1));
      cycle();
    end
    chk("drain_empty", 64'(trace_valid), 64'd0);

    // full FIFO with simultaneous push and pop: no drop
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      retire(64'h200 + 64'(i * 4), 5'd1, 1'b1, 64'(i));
      cycle();
    end
    chk("full_drop_before", 64'(drop_count), 64'd2);
    retire(64'h300, 5'd2, 1'b1, 64'h33);
    trace_ready = 1'b1;
    cycle();
    chk("pushpop_drop", 64'(drop_count), 64'd2);
    chk("pushpop_instret", 64'(instret_count), 64'd19);
    chk("pushpop_head", trace_pc, 64'h204);
    trace_ready = 1'b0;
    retire(64'h304, 5'd2, 1'b1, 64'h34);
    cycle();
    chk("still_full_drop", 64'(drop_count), 64'd3);
    wb_valid = 1'b0;
    trace_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_pc = (k < 7) ? 64'h204 + 64'(k * 4) : 64'h300;
      chk($sformatf("pp_drain%0d_pc", k), trace_pc, exp_pc);
      cycle();
    end

    // flush held open by pending records
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      retire(64'h100 + 64'(i * 4), 5'(i + 1), 1'b1, 64'(i));
      cycle();
    end
    wb_valid = 1'b0;
    end_program = 1'b1; cycle(); end_program = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk($sformatf("hold%0d_busy", i), 64'(busy), 64'd1);
      chk($sformatf("hold%0d_done", i), 64'(done), 64'd0);
    end
    trace_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 8 && trace_valid; k++) begin
      cycle();
      pops++;
    end
    chk("hold_pops", 64'(pops), 64'd4);
    chk("last_pop_done", 64'(done), 64'd0);
    chk("last_pop_busy", 64'(busy), 64'd1);
    cycle();
    chk("after_pop_done", 64'(done), 64'd1);
    chk("after_pop_cycle", 64'(cycle_count), 64'd20);
    chk("after_pop_instret", 64'(instret_count), 64'd4);

    // retirement without a register write
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    retire(64'h0, 5'd3, 1'b0, 64'hDEAD);
    cycle();
    chk("nowr_valid", 64'(trace_valid), 64'd1);
    chk("nowr_pc", trace_pc, 64'h0);
    chk("nowr_rd", 64'(trace_rd), 64'd0);
    chk("nowr_data", trace_data, 64'd0);
    chk("nowr_instret", 64'(instret_count), 64'd1);
    retire(64'h4, 5'd8, 1'b1, 64'h11); cycle();
    retire(64'h8, 5'd9, 1'b1, 64'h22); cycle();

    // reset mid-run with 3 records queued, then start is needed again
    do_reset();
    for (int i = 0; i < 3; i++) begin
      retire(64'h500, 5'd4, 1'b1, 64'h5);
      trace_ready = 1'b1;
      cycle();
      chk($sformatf("postrst%0d_busy", i), 64'(busy), 64'd0);
      chk($sformatf("postrst%0d_instret", i), 64'(instret_count), 64'd0);
      chk($sformatf("postrst%0d_valid", i), 64'(trace_valid), 64'd0);
    end
    wb_valid = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    chk("restart_busy", 64'(busy), 64'd1);

    // randomized episodes against the model
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        start = (c == 0) || ($urandom_range(0, 7) == 0);
        end_program = (c >= 60) || (c > 40 && $urandom_range(0, 3) == 0);
        wb_valid = ($urandom_range(0, 9) < 6);
        wb_pc = {$urandom, $urandom};
        wb_rd = 5'($urandom);
        wb_reg_write = ($urandom_range(0, 3) != 0);
        wb_data = {$urandom, $urandom};
        trace_ready = (ep % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
        cycle();
      end
      start = 1'b0;
      trace_ready = 1'b1;
      for (int c = 0; c < 40 && !done; c++) begin
        wb_valid = ($urandom_range(0, 1) == 1);
        wb_pc = {$urandom, $urandom};
        cycle();
      end
      chk($sformatf("rand%0d_done", ep), 64'(done), 64'd1);
      wb_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/retire_trace_monitor.md
Name: retire_trace_monitor

Overview:
- Observes the write-back stage of cpu_pipelined and records every retired instruction into a small FIFO.
- The FIFO drains to a trace consumer over valid/ready.
- Counts run cycles and retired instructions, detects end_program, and waits a fixed number of flush cycles before asserting done.
- Gives benches and the FPGA debug path a synthesizable run/retire/stop monitor in place of ad-hoc bench loops.

Parameters:
- XLEN, 64, width of PC and write-back data
- FIFO_DEPTH, 8, number of trace records; power of two, at least 2
- FLUSH_CYCLES, 5, cycles waited after end_program before done
- CNT_W, 32, width of cycle, instret and drop counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins measurement
- end_program  in  1  level from CPU; program finished
- wb_valid  in  1  an instruction retires this cycle
- wb_pc  in  XLEN  PC of the retiring instruction
- wb_rd  in  5  destination register
- wb_reg_write  in  1  retiring instruction writes rd
- wb_data  in  XLEN  write-back value
- trace_valid  out  1  head record available
- trace_ready  in  1  consumer accepts the head record
- trace_pc  out  XLEN  head record PC
- trace_rd  out  5  head record rd; forced to 0 when its reg_write is 0
- trace_data  out  XLEN  head record data; forced to 0 when its reg_write is 0
- cycle_count  out  CNT_W  cycles spent in RUN and FLUSH
- instret_count  out  CNT_W  accepted plus dropped retirements
- drop_count  out  CNT_W  retirements lost to a full FIFO
- busy  out  1  state is RUN or FLUSH
- done  out  1  state is DONE

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; FIFO emptied; flush counter=0.
  - All counters 0; trace_valid=0, busy=0, done=0; trace_pc/rd/data=0.
- IDLE:
  - start=1 → RUN on the next edge.
  - wb_valid and end_program are ignored; counters hold.
- RUN:
  - cycle_count +1 every edge, including the edge that leaves RUN.
  - end_program=1 → FLUSH, flush counter loaded with FLUSH_CYCLES.
  - start is ignored.
- FLUSH:
  - cycle_count +1 every edge; flush counter −1 every edge.
  - When the flush counter reads 0 and the FIFO is empty → DONE.
  - If the FIFO is still non-empty, the state stays in FLUSH with the counter held at 0 until the FIFO drains.
  - end_program is not re-sampled.
- DONE:
  - done=1, busy=0; all counters frozen.
  - Further wb_valid is ignored.
  - Left only by reset; start is ignored.
- Capture (RUN and FLUSH only):
  - wb_valid=1 → instret_count +1.
  - The record {wb_pc, wb_rd, wb_reg_write, wb_data} is pushed unless the FIFO is full.
  - On full: the record is discarded and drop_count +1.
- Full and pop in the same cycle: the pop frees the slot, so the push is accepted and not dropped.
- Drain:
  - trace_valid = FIFO non-empty; outputs are driven from the head slot, not registered beyond it.
  - Pop when trace_valid && trace_ready. Draining is allowed in every state, including DONE.
- Push into an empty FIFO: trace_valid rises on the following cycle (1-cycle latency). No bypass path.
- Pointers: log2(FIFO_DEPTH)+1 bits; they wrap modulo 2·FIFO_DEPTH.
  - full: MSBs differ and the low bits are equal.
  - empty: pointers are equal.
- Counters saturate at all-ones; they never wrap.
- Reset asserted mid-run: immediate return to IDLE. FIFO contents are discarded and all counters are cleared.

Test Plan:
- Reset then start; 3 retirements (pc 0x0/0x4/0x8, rd 5/6/7, data 4, reg_write=1); trace_ready=1; end_program at cycle 6 → 3 records in order; DONE after 5 flush cycles; cycle_count=11, instret_count=3, drop_count=0.
- trace_ready=0; 10 back-to-back retirements with FIFO_DEPTH=8 → trace_valid=1, 8 records held, drop_count=2, instret_count=10. Then ready=1 → records pc 0x0..0x1C drain in order.
- FIFO full; wb_valid and trace_ready high in the same cycle → no drop; occupancy stays 8; drop_count unchanged.
- end_program with 4 records pending and ready=0 for 10 cycles → stays in FLUSH with busy=1. After ready=1, DONE one cycle after the last pop; cycle_count keeps increasing until then.
- wb_valid while reg_write=0 (beq at pc 0x0) → record with trace_rd=0 and trace_data=0; instret_count increments.
- Reset pulsed low during RUN with 3 records queued → trace_valid=0 and all counters 0 immediately; start is required again.
